// File: rtl/pc_seq_pkg.sv
// Shared defaults and the command-select encoding for the program counter
// sequencer and its return-address stack.
package pc_seq_pkg;

    localparam int DEF_ADDR_W      = 6;
    localparam int DEF_STEP        = 4;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_RESET_ADDR  = 0;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_JMP,
        CMD_CALL,
        CMD_RET,
        CMD_BR,
        CMD_INC
    } cmd_t;

    // Fixed priority jmp > call > ret > br > inc; only the winner ever acts.
    function automatic cmd_t select_cmd(
        input logic jmp,
        input logic call,
        input logic ret,
        input logic br,
        input logic inc
    );
        cmd_t sel;
        sel = CMD_NONE;
        if (jmp)
            sel = CMD_JMP;
        else if (call)
            sel = CMD_CALL;
        else if (ret)
            sel = CMD_RET;
        else if (br)
            sel = CMD_BR;
        else if (inc)
            sel = CMD_INC;
        return sel;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO. Refuses push when full and pop when empty, and tells
// the parent about each refusal so it can raise its sticky error flags.
module pc_return_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_STACK_DEPTH,
    localparam int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty,
    output logic              push_refused,
    output logic              pop_refused
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign full         = (sp == SP_W'(DEPTH));
    assign empty        = (sp == '0);
    assign push_ok      = push & ~full;
    assign pop_ok       = pop & ~push & ~empty;
    assign push_refused = push & full;
    assign pop_refused  = pop & ~push & empty;

    // Top of stack is the entry just below sp; reads zero when empty.
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SP_W'(i + 1) == sp)
                top_data = mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (SP_W'(i) == sp)
                    mem[i] <= push_data;
            end
            sp <= sp + SP_W'(1);
        end else if (pop_ok) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, absolute jump, relative branch and
// call/return through an internal stack, with global hold and sticky errors.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STEP        = DEF_STEP,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int RESET_ADDR  = DEF_RESET_ADDR,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pc_inc,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_add,
    input  logic              br,
    input  logic [ADDR_W-1:0] br_off,
    input  logic              call,
    input  logic              ret,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] add,
    output logic [SP_W-1:0]   sp,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              ovf,
    output logic              unf
);

    cmd_t              cmd;
    logic [ADDR_W-1:0] inc_add;
    logic [ADDR_W-1:0] br_add;
    logic [ADDR_W-1:0] top_data;
    logic [ADDR_W-1:0] next_add;
    logic              push_refused;
    logic              pop_refused;

    assign cmd     = en ? select_cmd(jmp, call, ret, br, pc_inc) : CMD_NONE;
    assign inc_add = add + ADDR_W'(STEP);
    assign br_add  = add + br_off;

    pc_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk          (clk),
        .rst          (rst),
        .push         (cmd == CMD_CALL),
        .pop          (cmd == CMD_RET),
        .push_data    (inc_add),
        .top_data     (top_data),
        .sp           (sp),
        .full         (stk_full),
        .empty        (stk_empty),
        .push_refused (push_refused),
        .pop_refused  (pop_refused)
    );

    // A refused call or return leaves the address where it is.
    always_comb begin
        next_add = add;
        case (cmd)
            CMD_JMP:  next_add = jmp_add;
            CMD_CALL: next_add = push_refused ? add : jmp_add;
            CMD_RET:  next_add = pop_refused ? add : top_data;
            CMD_BR:   next_add = br_add;
            CMD_INC:  next_add = inc_add;
            default:  next_add = add;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            add <= ADDR_W'(RESET_ADDR);
        else
            add <= next_add;
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push_refused)
                ovf <= 1'b1;
            else if (clr_err)
                ovf <= 1'b0;
            if (pop_refused)
                unf <= 1'b1;
            else if (clr_err)
                unf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model pushes the expected
// state per driven cycle, popped and compared one cycle later.
module tb_pc_sequencer;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_JMP  = 6'b000001;
    localparam logic [5:0] C_CALL = 6'b000010;
    localparam logic [5:0] C_RET  = 6'b000100;
    localparam logic [5:0] C_BR   = 6'b001000;
    localparam logic [5:0] C_INC  = 6'b010000;
    localparam logic [5:0] C_CLR  = 6'b100000;

    typedef struct {
        logic [5:0] add;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       pc_inc;
    logic       jmp;
    logic [5:0] jmp_add;
    logic       br;
    logic [5:0] br_off;
    logic       call;
    logic       ret;
    logic       clr_err;
    logic [5:0] add;
    logic [2:0] sp;
    logic       stk_full;
    logic       stk_empty;
    logic       ovf;
    logic       unf;

    int checkCount = 0;
    int errorCount = 0;

    exp_t       sb[$];
    logic [5:0] mAdd;
    logic       mOvf;
    logic       mUnf;
    logic [5:0] mStack[$];

    pc_sequencer #(
        .ADDR_W      (6),
        .STEP        (4),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pc_inc    (pc_inc),
        .jmp       (jmp),
        .jmp_add   (jmp_add),
        .br        (br),
        .br_off    (br_off),
        .call      (call),
        .ret       (ret),
        .clr_err   (clr_err),
        .add       (add),
        .sp        (sp),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d required %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mAdd = 6'd0;
        mOvf = 1'b0;
        mUnf = 1'b0;
        mStack.delete();
        sb.delete();
    endtask

    // Reference behaviour written from the command descriptions.
    task automatic modelStep(input logic e, input logic [5:0] c,
                             input logic [5:0] ja, input logic [5:0] bo);
        exp_t x;
        logic ovfSet;
        logic unfSet;
        ovfSet = 1'b0;
        unfSet = 1'b0;
        if (e) begin
            if (c[0]) begin
                mAdd = ja;
            end else if (c[1]) begin
                if (mStack.size() >= 4) begin
                    ovfSet = 1'b1;
                end else begin
                    mStack.push_back(mAdd + 6'd4);
                    mAdd = ja;
                end
            end else if (c[2]) begin
                if (mStack.size() == 0)
                    unfSet = 1'b1;
                else
                    mAdd = mStack.pop_back();
            end else if (c[3]) begin
                mAdd = mAdd + bo;
            end else if (c[4]) begin
                mAdd = mAdd + 6'd4;
            end
        end
        if (ovfSet)
            mOvf = 1'b1;
        else if (c[5])
            mOvf = 1'b0;
        if (unfSet)
            mUnf = 1'b1;
        else if (c[5])
            mUnf = 1'b0;
        x.add = mAdd;
        x.sp  = 3'(mStack.size());
        x.ovf = mOvf;
        x.unf = mUnf;
        sb.push_back(x);
    endtask

    task automatic compareTop();
        exp_t x;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 0, 1);
        end else begin
            x = sb.pop_front();
            checkOutput("add", int'(add), int'(x.add));
            checkOutput("sp", int'(sp), int'(x.sp));
            checkOutput("ovf", int'(ovf), int'(x.ovf));
            checkOutput("unf", int'(unf), int'(x.unf));
            checkOutput("stk_full", int'(stk_full), int'(x.sp == 3'd4));
            checkOutput("stk_empty", int'(stk_empty), int'(x.sp == 3'd0));
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [5:0] c,
                                 input logic [5:0] ja, input logic [5:0] bo);
        @(negedge clk);
        en      = e;
        jmp     = c[0];
        call    = c[1];
        ret     = c[2];
        br      = c[3];
        pc_inc  = c[4];
        clr_err = c[5];
        jmp_add = ja;
        br_off  = bo;
        modelStep(e, c, ja, bo);
        @(posedge clk);
        #1;
        compareTop();
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0; pc_inc = 1'b0; jmp = 1'b0; jmp_add = 6'd0; br = 1'b0;
        br_off = 6'd0; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_add", int'(add), 0);
        checkOutput("rst_sp", int'(sp), 0);
        checkOutput("rst_flags", int'({ovf, unf}), 0);
        checkOutput("rst_empty", int'(stk_empty), 1);
        @(negedge clk);
        rst = 1'b1;

        // Increment through the wrap at 64
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, C_INC, 6'd0, 6'd0);
            checkOutput("inc_seq", int'(add), (4 * k) % 64);
        end
        applyStimulus(1'b1, C_INC, 6'd0, 6'd0);
        @(negedge clk);
        pc_inc = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_add", int'(add), 0);
        checkOutput("async_rst_sp", int'(sp), 0);
        modelReset();
        @(negedge clk);
        pc_inc = 1'b0;
        rst = 1'b1;

        // Relative branch and jmp priority
        applyStimulus(1'b1, C_JMP, 6'd8, 6'd0);
        applyStimulus(1'b1, C_BR, 6'd0, 6'h3C);
        checkOutput("br_neg", int'(add), 4);
        applyStimulus(1'b1, C_BR, 6'd0, 6'h08);
        checkOutput("br_pos", int'(add), 12);
        applyStimulus(1'b1, C_JMP | C_BR, 6'd32, 6'h08);
        checkOutput("jmp_prio", int'(add), 32);

        // Nested call / return
        applyStimulus(1'b1, C_JMP, 6'd8, 6'd0);
        applyStimulus(1'b1, C_CALL, 6'd40, 6'd0);
        applyStimulus(1'b1, C_CALL, 6'd20, 6'd0);
        checkOutput("call2_sp", int'(sp), 2);
        applyStimulus(1'b1, C_RET, 6'd0, 6'd0);
        checkOutput("ret1_add", int'(add), 44);
        applyStimulus(1'b1, C_RET, 6'd0, 6'd0);
        checkOutput("ret2_add", int'(add), 12);
        checkOutput("ret2_empty", int'(stk_empty), 1);

        // Overflow on fifth call, then clear and drain
        applyStimulus(1'b1, C_JMP, 6'd0, 6'd0);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, C_CALL, 6'(16 + 4 * k), 6'd0);
        checkOutput("ovf_add", int'(add), 28);
        checkOutput("ovf_flag", int'(ovf), 1);
        checkOutput("ovf_full", int'(stk_full), 1);
        applyStimulus(1'b1, C_CLR, 6'd0, 6'd0);
        checkOutput("ovf_clr", int'(ovf), 0);
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, C_RET, 6'd0, 6'd0);
        checkOutput("drain_add", int'(add), 4);

        // Underflow; error wins over a simultaneous clear
        applyStimulus(1'b1, C_RET, 6'd0, 6'd0);
        checkOutput("unf_flag", int'(unf), 1);
        applyStimulus(1'b1, C_RET | C_CLR, 6'd0, 6'd0);
        checkOutput("unf_wins", int'(unf), 1);

        // Hold with en low, clear still honoured
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, C_INC | C_CALL | C_RET, 6'd50, 6'd0);
        checkOutput("hold_add", int'(add), 4);
        applyStimulus(1'b0, C_CLR | C_INC, 6'd0, 6'd0);
        checkOutput("hold_clr", int'(unf), 0);
        applyStimulus(1'b1, C_INC, 6'd0, 6'd0);
        checkOutput("resume_inc", int'(add), 8);

        // Random command mix against the model
        for (int k = 0; k < 400; k++) begin
            logic [5:0] c;
            c = C_NONE;
            if ($urandom_range(0, 7) == 0) c = c | C_JMP;
            if ($urandom_range(0, 3) == 0) c = c | C_CALL;
            if ($urandom_range(0, 3) == 0) c = c | C_RET;
            if ($urandom_range(0, 3) == 0) c = c | C_BR;
            if ($urandom_range(0, 1) == 0) c = c | C_INC;
            if ($urandom_range(0, 7) == 0) c = c | C_CLR;
            applyStimulus($urandom_range(0, 9) != 0, c,
                          6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
